dcache_miss_handler: RTL and testbench

// Commit-side dcache miss/refill engine. Accepts one miss request (line paddr, victim way, dirty flag, victim tag),

---
 rtl/dcache_miss_handler.sv | 209 ++++++++++++++++++++
 tb/tb_dcache_miss_handler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_handler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_miss_handler: dcache miss engine - dirty victim write-back, refill   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module dcache_miss_handler #(
  parameter int WAY_NUM     = 2,
  parameter int BLOCK_WORDS = 4,
  parameter int TAG_W       = 22
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        req_paddr_i,
  input  logic [WAY_NUM-1:0] req_way_i,
  input  logic               req_dirty_i,
  input  logic [19:0]        req_vtag_i,
  output logic [31:0]        cache_addr_o,
  output logic [WAY_NUM-1:0] cache_way_o,
  output logic               cache_tag_we_o,
  output logic [TAG_W-1:0]   cache_tag_o,
  output logic [3:0]         cache_strb_o,
  output logic [31:0]        cache_wdata_o,
  input  logic [31:0]        cache_rdata_i,
  output logic               rd_req_valid_o,
  input  logic               rd_req_ready_i,
  output logic [31:0]        rd_addr_o,
  input  logic               rd_data_valid_i,
  input  logic [31:0]        rd_data_i,
  input  logic               rd_last_i,
  output logic               wr_req_valid_o,
  input  logic               wr_req_ready_i,
  output logic [31:0]        wr_addr_o,
  output logic               wr_data_valid_o,
  input  logic               wr_data_ready_i,
  output logic [31:0]        wr_data_o,
  output logic               wr_last_o,
  input  logic               wr_done_i,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_RD   = 3'd1,
    S_WB_REQ  = 3'd2,
    S_WB_DATA = 3'd3,
    S_WB_RESP = 3'd4,
    S_RF_REQ  = 3'd5,
    S_RF_DATA = 3'd6,
    S_RF_TAG  = 3'd7
  } state_e;

  localparam logic [1:0] LAST_BEAT = 2'(BLOCK_WORDS - 1);
  localparam logic [2:0] RD_CYCLES = 3'(BLOCK_WORDS);

  state_e             state_q, state_d;
  logic [27:0]        line_q, line_d;
  logic [WAY_NUM-1:0] way_q, way_d;
  logic [19:0]        vtag_q, vtag_d;
  logic [1:0]         beat_q, beat_d;
  logic [2:0]         rdcnt_q, rdcnt_d;
  logic [31:0]        wb_buf_q [BLOCK_WORDS];
  logic [31:0]        wb_buf_d [BLOCK_WORDS];

  // Line offset bits are ignored and the refill completes by beat count.
  logic unused_inputs;
  assign unused_inputs = ^{req_paddr_i[3:0], rd_last_i};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      line_q   <= '0;
      way_q    <= '0;
      vtag_q   <= '0;
      beat_q   <= '0;
      rdcnt_q  <= '0;
      wb_buf_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      way_q    <= way_d;
      vtag_q   <= vtag_d;
      beat_q   <= beat_d;
      rdcnt_q  <= rdcnt_d;
      wb_buf_q <= wb_buf_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    line_d          = line_q;
    way_d           = way_q;
    vtag_d          = vtag_q;
    beat_d          = beat_q;
    rdcnt_d         = rdcnt_q;
    wb_buf_d        = wb_buf_q;
    req_ready_o     = 1'b0;
    cache_addr_o    = '0;
    cache_way_o     = '0;
    cache_tag_we_o  = 1'b0;
    cache_tag_o     = '0;
    cache_strb_o    = 4'h0;
    cache_wdata_o   = '0;
    rd_req_valid_o  = 1'b0;
    rd_addr_o       = '0;
    wr_req_valid_o  = 1'b0;
    wr_addr_o       = '0;
    wr_data_valid_o = 1'b0;
    wr_data_o       = '0;
    wr_last_o       = 1'b0;
    done_o          = 1'b0;
    busy_o          = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          line_d  = req_paddr_i[31:4];
          way_d   = req_way_i;
          vtag_d  = req_vtag_i;
          beat_d  = '0;
          rdcnt_d = '0;
          state_d = req_dirty_i ? S_WB_RD : S_RF_REQ;
        end
      end

      // One extra cycle after the last address collects the final read word.
      S_WB_RD: begin
        if (rdcnt_q < RD_CYCLES) begin
          cache_addr_o = {line_q, rdcnt_q[1:0], 2'b00};
          cache_way_o  = way_q;
        end
        if (rdcnt_q != 3'd0) begin
          wb_buf_d[rdcnt_q[1:0] - 2'd1] = cache_rdata_i;
        end
        if (rdcnt_q == RD_CYCLES) begin
          rdcnt_d = '0;
          state_d = S_WB_REQ;
        end else begin
          rdcnt_d = rdcnt_q + 3'd1;
        end
      end

      S_WB_REQ: begin
        wr_req_valid_o = 1'b1;
        wr_addr_o      = {vtag_q, line_q[7:0], 4'h0};
        if (wr_req_ready_i) begin
          beat_d  = '0;
          state_d = S_WB_DATA;
        end
      end

      S_WB_DATA: begin
        wr_data_valid_o = 1'b1;
        wr_data_o       = wb_buf_q[beat_q];
        wr_last_o       = (beat_q == LAST_BEAT);
        if (wr_data_ready_i) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_WB_RESP;
          end
        end
      end

      S_WB_RESP: begin
        if (wr_done_i) begin
          state_d = S_RF_REQ;
        end
      end

      S_RF_REQ: begin
        rd_req_valid_o = 1'b1;
        rd_addr_o      = {line_q, 4'h0};
        if (rd_req_ready_i) begin
          beat_d  = '0;
          state_d = S_RF_DATA;
        end
      end

      S_RF_DATA: begin
        if (rd_data_valid_i) begin
          cache_addr_o  = {line_q, beat_q, 2'b00};
          cache_way_o   = way_q;
          cache_strb_o  = 4'hF;
          cache_wdata_o = rd_data_i;
          beat_d        = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_RF_TAG;
          end
        end
      end

      S_RF_TAG: begin
        cache_addr_o   = {line_q, 4'h0};
        cache_way_o    = way_q;
        cache_tag_we_o = 1'b1;
        cache_tag_o    = TAG_W'({line_q[27:8], 1'b1, 1'b0});
        done_o         = 1'b1;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_handler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dcache_miss_handler: directed bench for dcache_miss_handler             |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_dcache_miss_handler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_dirty_i;
  logic [31:0] req_paddr_i;
  logic [1:0]  req_way_i;
  logic [19:0] req_vtag_i;
  logic [31:0] cache_addr_o, cache_wdata_o, cache_rdata_i;
  logic [1:0]  cache_way_o;
  logic        cache_tag_we_o;
  logic [21:0] cache_tag_o;
  logic [3:0]  cache_strb_o;
  logic        rd_req_valid_o, rd_req_ready_i, rd_data_valid_i, rd_last_i;
  logic [31:0] rd_addr_o, rd_data_i;
  logic        wr_req_valid_o, wr_req_ready_i, wr_data_valid_o, wr_data_ready_i, wr_last_o, wr_done_i;
  logic [31:0] wr_addr_o, wr_data_o;
  logic        busy_o, done_o;

  always #5 clk = ~clk;

  dcache_miss_handler #(.WAY_NUM(2), .BLOCK_WORDS(4), .TAG_W(22)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_paddr_i(req_paddr_i),
    .req_way_i(req_way_i), .req_dirty_i(req_dirty_i), .req_vtag_i(req_vtag_i),
    .cache_addr_o(cache_addr_o), .cache_way_o(cache_way_o), .cache_tag_we_o(cache_tag_we_o),
    .cache_tag_o(cache_tag_o), .cache_strb_o(cache_strb_o), .cache_wdata_o(cache_wdata_o),
    .cache_rdata_i(cache_rdata_i),
    .rd_req_valid_o(rd_req_valid_o), .rd_req_ready_i(rd_req_ready_i), .rd_addr_o(rd_addr_o),
    .rd_data_valid_i(rd_data_valid_i), .rd_data_i(rd_data_i), .rd_last_i(rd_last_i),
    .wr_req_valid_o(wr_req_valid_o), .wr_req_ready_i(wr_req_ready_i), .wr_addr_o(wr_addr_o),
    .wr_data_valid_o(wr_data_valid_o), .wr_data_ready_i(wr_data_ready_i), .wr_data_o(wr_data_o),
    .wr_last_o(wr_last_o), .wr_done_i(wr_done_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {logic [31:0] addr; logic [31:0] data; logic [1:0] way;} cw_t;
  typedef struct {logic [31:0] data; logic last;} wb_t;
  cw_t         dq[$];
  cw_t         tq[$];
  wb_t         bq[$];
  logic [31:0] waq[$];
  logic [31:0] raq[$];
  int          done_cyc[$];
  int          acc_cyc[$];
  logic [31:0] sram [4];

  int          wstall, rdelay, gap, ws_cnt, rd_cnt, gap_cnt, rbeat;
  int          n_done, n_acc, cyc, idle_after;
  logic        rd_phase, wb_last_seen, prev_wstall, prev_rstall, prev_wlast;
  logic [31:0] rbase, prev_wdata, prev_raddr;

  task automatic clear_sb();
    dq.delete(); tq.delete(); bq.delete(); waq.delete(); raq.delete();
    done_cyc.delete(); acc_cyc.delete();
    ws_cnt = 0; rd_cnt = 0; gap_cnt = 0; rbeat = 0;
    n_done = 0; n_acc = 0; cyc = 0; idle_after = 0;
    rd_phase = 0; wb_last_seen = 0; prev_wstall = 0; prev_rstall = 0;
  endtask

  // Bus/memory responder: decides this cycle's inputs from the DUT's state outputs.
  task automatic bus_respond();
    wr_req_ready_i = wr_req_valid_o;
    wr_data_ready_i = 1'b0;
    if (wr_data_valid_o) begin
      if (ws_cnt < wstall) begin
        ws_cnt++;
      end else begin
        wr_data_ready_i = 1'b1;
        ws_cnt = 0;
      end
    end
    wr_done_i = wb_last_seen;
    wb_last_seen = 1'b0;
    rd_req_ready_i = rd_req_valid_o && (rd_cnt >= rdelay);
    if (rd_req_valid_o && !rd_req_ready_i) rd_cnt++;
    rd_data_valid_i = 1'b0;
    rd_data_i = 32'h0;
    rd_last_i = 1'b0;
    if (rd_phase && rbeat < 4) begin
      if (gap_cnt < gap) begin
        gap_cnt++;
      end else begin
        rd_data_valid_i = 1'b1;
        rd_data_i = rbase + 32'(rbeat);
        rd_last_i = (rbeat == 3);
      end
    end
  endtask

  // Observe one cycle, record transactions, then advance to the next negedge.
  task automatic sample();
    logic [1:0] ra;
    #1;
    if (cache_strb_o != 4'h0) dq.push_back('{cache_addr_o, cache_wdata_o, cache_way_o});
    if (cache_tag_we_o) tq.push_back('{cache_addr_o, 32'(cache_tag_o), cache_way_o});
    if (wr_req_valid_o && wr_req_ready_i) waq.push_back(wr_addr_o);
    if (rd_req_valid_o && rd_req_ready_i) begin
      raq.push_back(rd_addr_o);
      rd_phase = 1'b1; rbeat = 0; gap_cnt = 0; rd_cnt = 0;
    end
    if (rd_data_valid_i) begin
      rbeat++;
      gap_cnt = 0;
      if (rbeat == 4) rd_phase = 1'b0;
    end
    if (wr_data_valid_o && wr_data_ready_i) begin
      bq.push_back('{wr_data_o, wr_last_o});
      if (wr_last_o) wb_last_seen = 1'b1;
    end
    if (prev_wstall) begin
      chk("wr_valid_held", wr_data_valid_o, 1);
      chk("wr_data_held", wr_data_o, prev_wdata);
      chk("wr_last_held", wr_last_o, prev_wlast);
    end
    if (prev_rstall) begin
      chk("rd_req_held", rd_req_valid_o, 1);
      chk("rd_addr_held", rd_addr_o, prev_raddr);
    end
    prev_wstall = wr_data_valid_o && !wr_data_ready_i;
    prev_wdata  = wr_data_o;
    prev_wlast  = wr_last_o;
    prev_rstall = rd_req_valid_o && !rd_req_ready_i;
    prev_raddr  = rd_addr_o;
    if (done_o) begin n_done++; done_cyc.push_back(cyc); end
    if (req_valid_i && req_ready_o) begin n_acc++; acc_cyc.push_back(cyc); end
    if (n_done == 1 && !busy_o) idle_after++;
    ra = cache_addr_o[3:2];
    cyc++;
    @(negedge clk);
    cache_rdata_i = sram[ra];
  endtask

  task automatic check_line(input string tn, input logic [31:0] paddr, input logic [1:0] way,
                            input logic dirty, input logic [19:0] vtag, input logic [31:0] rb);
    chk({tn, " done_cnt"}, n_done, 1);
    chk({tn, " acc_cnt"}, n_acc, 1);
    chk({tn, " n_dwrites"}, dq.size(), 4);
    for (int i = 0; i < 4 && i < dq.size(); i++) begin
      logic [1:0] ib;
      ib = 2'(i);
      chk($sformatf("%s dw%0d_addr", tn, i), dq[i].addr, {paddr[31:4], ib, 2'b00});
      chk($sformatf("%s dw%0d_data", tn, i), dq[i].data, rb + 32'(i));
      chk($sformatf("%s dw%0d_way", tn, i), dq[i].way, way);
    end
    chk({tn, " n_tagw"}, tq.size(), 1);
    if (tq.size() > 0) begin
      chk({tn, " tag_addr"}, tq[0].addr, {paddr[31:4], 4'h0});
      chk({tn, " tag_val"}, tq[0].data, 32'({paddr[31:12], 2'b10}));
      chk({tn, " tag_way"}, tq[0].way, way);
    end
    chk({tn, " n_rdreq"}, raq.size(), 1);
    if (raq.size() > 0) chk({tn, " rd_addr"}, raq[0], {paddr[31:4], 4'h0});
    if (dirty) begin
      chk({tn, " n_wrreq"}, waq.size(), 1);
      if (waq.size() > 0) chk({tn, " wr_addr"}, waq[0], {vtag, paddr[11:4], 4'h0});
      chk({tn, " n_beats"}, bq.size(), 4);
      for (int i = 0; i < 4 && i < bq.size(); i++) begin
        chk($sformatf("%s beat%0d_data", tn, i), bq[i].data, sram[i]);
        chk($sformatf("%s beat%0d_last", tn, i), bq[i].last, (i == 3));
      end
    end else begin
      chk({tn, " no_wrreq"}, waq.size(), 0);
      chk({tn, " no_beats"}, bq.size(), 0);
    end
  endtask

  task automatic run_seq(input string tn, input logic [31:0] paddr, input logic [1:0] way,
                         input logic dirty, input logic [19:0] vtag, input int ws,
                         input int rd, input int gp, input logic [31:0] rb);
    clear_sb();
    wstall = ws; rdelay = rd; gap = gp; rbase = rb;
    req_paddr_i = paddr; req_way_i = way; req_dirty_i = dirty; req_vtag_i = vtag;
    for (int i = 0; i < 400 && n_done == 0; i++) begin
      req_valid_i = (n_acc == 0);
      bus_respond();
      sample();
    end
    req_valid_i = 1'b0;
    bus_respond();
    sample();
    check_line(tn, paddr, way, dirty, vtag, rb);
  endtask

  typedef struct {
    logic        rv, rrdy, dv;
    logic [31:0] dd;
    logic        e_rdy, e_busy, e_rqv;
    logic [31:0] e_addr;
    logic [1:0]  e_way;
    logic [3:0]  e_strb;
    logic [31:0] e_wd;
    logic        e_twe;
    logic [21:0] e_tag;
    logic        e_done;
  } vec_t;
  vec_t vt[8];

  initial begin
    sram[0] = 32'h11; sram[1] = 32'h12; sram[2] = 32'h13; sram[3] = 32'h14;
    // Clean miss, zero-wait bus, cycle by cycle from acceptance to return to IDLE.
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,        2'b00, 4'h0, 32'h0,  1'b0, 22'h0,     1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0,        2'b00, 4'h0, 32'h0,  1'b0, 22'h0,     1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 32'h10000230, 2'b01, 4'hF, 32'hA0, 1'b0, 22'h0,     1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 32'h10000234, 2'b01, 4'hF, 32'hA1, 1'b0, 22'h0,     1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 32'h10000238, 2'b01, 4'hF, 32'hA2, 1'b0, 22'h0,     1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 32'h1000023C, 2'b01, 4'hF, 32'hA3, 1'b0, 22'h0,     1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h10000230, 2'b01, 4'h0, 32'h0,  1'b1, 22'h040002, 1'b1};
    vt[7] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,        2'b00, 4'h0, 32'h0,  1'b0, 22'h0,     1'b0};

    rst_n = 1'b0;
    req_valid_i = 0; req_paddr_i = 0; req_way_i = 0; req_dirty_i = 0; req_vtag_i = 0;
    cache_rdata_i = 0; rd_req_ready_i = 0; rd_data_valid_i = 0; rd_data_i = 0; rd_last_i = 0;
    wr_req_ready_i = 0; wr_data_ready_i = 0; wr_done_i = 0;
    wstall = 0; rdelay = 0; gap = 0; rbase = 0;
    clear_sb();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst req_ready", req_ready_o, 1);
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst valids", {rd_req_valid_o, wr_req_valid_o, wr_data_valid_o}, 3'b000);
    chk("rst cache_ctl", {cache_way_o, cache_strb_o, cache_tag_we_o}, 7'h0);
    @(negedge clk);

    req_paddr_i = 32'h1000_0234; req_way_i = 2'b01; req_dirty_i = 1'b0; req_vtag_i = 20'h0;
    for (int i = 0; i < 8; i++) begin
      req_valid_i = vt[i].rv;
      rd_req_ready_i = vt[i].rrdy;
      rd_data_valid_i = vt[i].dv;
      rd_data_i = vt[i].dd;
      rd_last_i = (i == 5);
      #1;
      chk($sformatf("tbl%0d req_ready", i), req_ready_o, vt[i].e_rdy);
      chk($sformatf("tbl%0d busy", i), busy_o, vt[i].e_busy);
      chk($sformatf("tbl%0d rd_req_valid", i), rd_req_valid_o, vt[i].e_rqv);
      if (vt[i].e_rqv) chk($sformatf("tbl%0d rd_addr", i), rd_addr_o, 32'h1000_0230);
      chk($sformatf("tbl%0d wr_valids", i), {wr_req_valid_o, wr_data_valid_o}, 2'b00);
      chk($sformatf("tbl%0d cache_addr", i), cache_addr_o, vt[i].e_addr);
      chk($sformatf("tbl%0d cache_way", i), cache_way_o, vt[i].e_way);
      chk($sformatf("tbl%0d strb", i), cache_strb_o, vt[i].e_strb);
      if (vt[i].e_strb != 4'h0) chk($sformatf("tbl%0d wdata", i), cache_wdata_o, vt[i].e_wd);
      chk($sformatf("tbl%0d tag_we", i), cache_tag_we_o, vt[i].e_twe);
      if (vt[i].e_twe) chk($sformatf("tbl%0d tag", i), cache_tag_o, vt[i].e_tag);
      chk($sformatf("tbl%0d done", i), done_o, vt[i].e_done);
      @(negedge clk);
    end
    req_valid_i = 0; rd_req_ready_i = 0; rd_data_valid_i = 0; rd_last_i = 0;

    run_seq("dirty", 32'h1000_0234, 2'b01, 1'b1, 20'h20000, 0, 0, 0, 32'hA0);
    run_seq("bkpr", 32'h1000_0234, 2'b10, 1'b1, 20'h20000, 3, 5, 0, 32'hA0);
    run_seq("gaps", 32'h2345_6788, 2'b10, 1'b0, 20'h0, 0, 0, 2, 32'hC0);

    // Reset while the third write-back beat is on the bus.
    begin
      logic hit;
      hit = 1'b0;
      clear_sb();
      wstall = 0; rdelay = 0; gap = 0; rbase = 32'hB0;
      req_paddr_i = 32'h1000_0234; req_way_i = 2'b10; req_dirty_i = 1'b1; req_vtag_i = 20'h20000;
      for (int i = 0; i < 200 && !hit; i++) begin
        req_valid_i = (n_acc == 0);
        bus_respond();
        if (wr_data_valid_o && bq.size() == 2) hit = 1'b1;
        else sample();
      end
      chk("rst_mid reached_beat2", hit, 1);
      #1;
      chk("rst_mid beat2_data", wr_data_o, sram[2]);
      wr_data_ready_i = 1'b0;
      rst_n = 1'b0;
      sample();
      prev_wstall = 1'b0; prev_rstall = 1'b0; wb_last_seen = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("rst_mid req_ready", req_ready_o, 1);
      chk("rst_mid busy", busy_o, 0);
      chk("rst_mid valids", {rd_req_valid_o, wr_req_valid_o, wr_data_valid_o}, 3'b000);
      chk("rst_mid tag_we", cache_tag_we_o, 0);
      chk("rst_mid strb_way", {cache_strb_o, cache_way_o}, 6'h0);
      req_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
        bus_respond();
        sample();
      end
      chk("rst_mid no_tagw", tq.size(), 0);
      chk("rst_mid no_done", n_done, 0);
    end

    // Request held high across two back-to-back clean misses.
    clear_sb();
    wstall = 0; rdelay = 0; gap = 0; rbase = 32'hD0;
    req_paddr_i = 32'h1000_0234; req_way_i = 2'b01; req_dirty_i = 1'b0; req_vtag_i = 20'h0;
    for (int i = 0; i < 400 && n_done < 2; i++) begin
      req_valid_i = (n_acc < 2);
      bus_respond();
      sample();
    end
    req_valid_i = 1'b0;
    chk("b2b done_cnt", n_done, 2);
    chk("b2b acc_cnt", n_acc, 2);
    if (acc_cyc.size() > 1 && done_cyc.size() > 0)
      chk("b2b accept_after_done", acc_cyc[1], done_cyc[0] + 1);
    chk("b2b idle_cycles", idle_after, 1);
    chk("b2b n_dwrites", dq.size(), 8);
    chk("b2b n_tagw", tq.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
